// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave register-write controller.
// Holds the transaction FSM encoding, status bit positions and ACK levels.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        PTR    = 3'd2,
        DATA   = 3'd3,
        IGNORE = 3'd4
    } state_t;

    localparam int ST_BUSY   = 0;
    localparam int ST_HIT    = 1;
    localparam int ST_RDERR  = 2;
    localparam int ST_PTRERR = 3;
    localparam int ST_WRAP   = 4;

    localparam logic ACK  = 1'b1;
    localparam logic NACK = 1'b0;

endpackage

// File: rtl/i2c_slave_reg_ctrl.sv
// Transaction controller behind the I2C slave byte receiver: address match,
// register-pointer load, data writes, per-byte ACK/NACK and sticky status.
module i2c_slave_reg_ctrl
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         NUM_REGS   = 16,
    parameter int         AW         = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx_start,
    input  logic          rx_stop,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    input  logic          status_clr,
    output logic          rx_ack,
    output logic          reg_we,
    output logic [AW-1:0] reg_addr,
    output logic [7:0]    reg_wdata,
    output logic [7:0]    wr_count,
    output logic [7:0]    status
);

    localparam logic [8:0]    NUM_REGS_W = 9'(NUM_REGS);
    localparam logic [AW-1:0] PTR_MAX    = AW'(NUM_REGS - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q;
    logic          hit_q, rd_err_q, ptr_err_q, wrap_q;

    logic ack_upd, ack_val, do_write, ptr_load;
    logic set_hit, set_rd, set_perr, set_wrap;

    // Handshake: rx_start/rx_stop/rx_valid are single-cycle pulses with no
    // back-pressure; each accepted byte yields a registered ACK one cycle later.
    always_comb begin
        state_d  = state_q;
        ack_upd  = 1'b0;
        ack_val  = NACK;
        do_write = 1'b0;
        ptr_load = 1'b0;
        set_hit  = 1'b0;
        set_rd   = 1'b0;
        set_perr = 1'b0;
        set_wrap = 1'b0;
        if (rx_start) begin
            // A byte arriving with START belongs to no transfer and is dropped.
            state_d = ADDR;
        end else begin
            if (rx_valid) begin
                case (state_q)
                    ADDR: begin
                        ack_upd = 1'b1;
                        if (rx_data[7:1] == SLAVE_ADDR && !rx_data[0]) begin
                            ack_val = ACK;
                            set_hit = 1'b1;
                            state_d = PTR;
                        end else begin
                            set_rd  = (rx_data[7:1] == SLAVE_ADDR);
                            state_d = IGNORE;
                        end
                    end
                    PTR: begin
                        ack_upd = 1'b1;
                        if ({1'b0, rx_data} < NUM_REGS_W) begin
                            ack_val  = ACK;
                            ptr_load = 1'b1;
                            state_d  = DATA;
                        end else begin
                            set_perr = 1'b1;
                            state_d  = IGNORE;
                        end
                    end
                    DATA: begin
                        ack_upd  = 1'b1;
                        ack_val  = ACK;
                        do_write = 1'b1;
                        set_wrap = (ptr_q == PTR_MAX);
                    end
                    IGNORE: ack_upd = 1'b1;
                    default: ;
                endcase
            end
            if (rx_stop) state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rx_ack    <= NACK;
            reg_we    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            wr_count  <= '0;
            ptr_q     <= '0;
            hit_q     <= 1'b0;
            rd_err_q  <= 1'b0;
            ptr_err_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            reg_we  <= do_write;
            if (ack_upd) rx_ack <= ack_val;
            if (do_write) begin
                reg_addr  <= ptr_q;
                reg_wdata <= rx_data;
                ptr_q     <= ptr_q + AW'(1);
                if (wr_count != 8'hFF) wr_count <= wr_count + 8'd1;
            end else if (ptr_load) begin
                ptr_q <= rx_data[AW-1:0];
            end
            if (rx_start) wr_count <= '0;
            // Set events outrank a simultaneous clear.
            hit_q     <= rx_start ? 1'b0 : ((hit_q & ~status_clr) | set_hit);
            rd_err_q  <= (rd_err_q  & ~status_clr) | set_rd;
            ptr_err_q <= (ptr_err_q & ~status_clr) | set_perr;
            wrap_q    <= (wrap_q    & ~status_clr) | set_wrap;
        end
    end

    always_comb begin
        status            = '0;
        status[ST_BUSY]   = (state_q != IDLE);
        status[ST_HIT]    = hit_q;
        status[ST_RDERR]  = rd_err_q;
        status[ST_PTRERR] = ptr_err_q;
        status[ST_WRAP]   = wrap_q;
    end

endmodule
